// File: rtl/audio_pkg.sv
// Shared constants, entry layout and FSM encoding for the note sequencer.
// Defaults assume a 25 MHz clock.
package audio_pkg;

    localparam logic [7:0]  NOTE_REST       = 8'd0;

    localparam int unsigned DEPTH_DEF       = 16;
    localparam int unsigned BEAT_CYCLES_DEF = 4194304;
    localparam int unsigned GAP_CYCLES_DEF  = 262144;

    localparam int unsigned ENTRY_W         = 16;
    localparam int unsigned NOTE_LSB        = 0;
    localparam int unsigned NOTE_W          = 8;
    localparam int unsigned DUR_LSB         = 8;
    localparam int unsigned DUR_W           = 8;

    typedef struct packed {
        logic [DUR_W-1:0]  dur;
        logic [NOTE_W-1:0] code;
    } note_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } seq_state_t;

    // Split a raw CPU write word into its note and duration fields.
    function automatic note_entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
        note_entry_t e;
        e.code = raw[NOTE_LSB +: NOTE_W];
        e.dur  = raw[DUR_LSB +: DUR_W];
        return e;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous note FIFO: drops writes while full and flags them in a sticky overflow bit.
// The head entry is presented combinationally so the sequencer can pop and load on one edge.
module note_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_wr_en,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_head_c,
    output logic                    o_full,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_overflow;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;

    // A write while full is lost even if a pop frees a slot on the same edge.
    assign w_push = i_wr_en && !r_full;
    assign w_pop  = i_pop && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (i_wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_head_c   = r_mem[r_rd_ptr];
    assign o_full     = r_full;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/note_sequencer.sv
// Plays queued notes for a whole number of beats, silencing the gate for a short
// articulation gap at the end of each note; pause freezes playback in place.
module note_sequencer
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned BEAT_CYCLES = BEAT_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ENTRY_W-1:0]      wr_data,
    input  logic                    pause,
    output logic [NOTE_W-1:0]       note,
    output logic                    gate,
    output logic                    busy,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int unsigned CNT_W   = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam bit          HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_START = HAS_GAP ? CNT_W'(BEAT_CYCLES - GAP_CYCLES) : '0;

    seq_state_t          r_state;
    logic [NOTE_W-1:0]   r_note;
    logic [DUR_W-1:0]    r_beats;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_gate;
    logic                r_busy;

    seq_state_t          w_state_nxt;
    logic [NOTE_W-1:0]   w_note_nxt;
    logic [DUR_W-1:0]    w_beats_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_gate_nxt;
    logic                w_pop;
    logic                w_last;
    logic                w_in_gap;
    logic [ENTRY_W-1:0]  w_head_raw;
    note_entry_t         w_head;
    logic [$clog2(DEPTH):0] w_count;

    note_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .i_pop      (w_pop),
        .o_head_c   (w_head_raw),
        .o_full     (full),
        .o_count    (w_count),
        .o_overflow (overflow)
    );

    assign w_head = unpack_entry(w_head_raw);
    assign w_last = (r_beats == DUR_W'(1)) && (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_note  <= NOTE_REST;
            r_beats <= '0;
            r_cnt   <= '0;
            r_gate  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_note  <= w_note_nxt;
            r_beats <= w_beats_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gate  <= w_gate_nxt;
            r_busy  <= (w_state_nxt == ST_PLAY);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_note_nxt  = r_note;
        w_beats_nxt = r_beats;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_note_nxt = NOTE_REST;
                if ((w_count != '0) && !pause) begin
                    w_pop = 1'b1;
                    if (w_head.dur != '0) begin
                        w_state_nxt = ST_PLAY;
                        w_note_nxt  = w_head.code;
                        w_beats_nxt = w_head.dur;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            ST_PLAY: begin
                if (!pause) begin
                    if (r_cnt == CNT_MAX) begin
                        w_cnt_nxt   = '0;
                        w_beats_nxt = r_beats - DUR_W'(1);
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                    // Chain straight into the next entry so consecutive notes have no idle cycle.
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                        w_note_nxt  = NOTE_REST;
                        w_beats_nxt = '0;
                        w_cnt_nxt   = '0;
                        if (w_count != '0) begin
                            w_pop = 1'b1;
                            if (w_head.dur != '0) begin
                                w_state_nxt = ST_PLAY;
                                w_note_nxt  = w_head.code;
                                w_beats_nxt = w_head.dur;
                            end
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_note_nxt  = NOTE_REST;
                w_beats_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Gate is derived from the post-edge state so it lines up with the registered note.
    assign w_in_gap   = HAS_GAP && (w_beats_nxt == DUR_W'(1)) && (w_cnt_nxt >= GAP_START);
    assign w_gate_nxt = (w_state_nxt == ST_PLAY) && (w_note_nxt != NOTE_REST)
                        && !pause && !w_in_gap;

    assign note  = r_note;
    assign gate  = r_gate;
    assign busy  = r_busy;
    assign count = w_count;

endmodule

// File: tb/tb_note_sequencer.sv
// Scenario bench for note_sequencer with short beats; expected notes and lengths are
// queued as entries are written and consumed as the sequencer plays them.
module tb_note_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BEAT  = 8;
    localparam int unsigned GAP   = 2;

    typedef struct {
        logic [7:0] note;
        int         len;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        pause;
    logic [7:0]  note;
    logic        gate;
    logic        busy;
    logic        full;
    logic [2:0]  count;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    sb_item_t sb_q[$];

    note_sequencer #(
        .DEPTH       (DEPTH),
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .pause    (pause),
        .note     (note),
        .gate     (gate),
        .busy     (busy),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [15:0] d, input bit exp_play);
        sb_item_t it;
        wr_en   = 1'b1;
        wr_data = d;
        if (exp_play) begin
            it.note = d[7:0];
            it.len  = int'(d[15:8]) * int'(BEAT);
            sb_q.push_back(it);
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (note !== 8'd0)     begin bad++; $display("FAIL rst_note got=%0d want=0", note); end
        total++; if (gate !== 1'b0)     begin bad++; $display("FAIL rst_gate got=%b want=0", gate); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (full !== 1'b0)     begin bad++; $display("FAIL rst_full got=%b want=0", full); end
        total++; if (count !== 3'd0)    begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", overflow); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        sb_item_t exp;
        int len = 0, hi = 0, lo = 0;
        bit order_bad = 0;
        bit held_bad  = 0;
        write_entry(16'h0219, 1'b1);
        total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", count); end
        total++; if (note !== 8'd0)  begin bad++; $display("FAIL single_early got=%0d want=0", note); end
        tick();
        exp = sb_q.pop_front();
        total++; if (note !== exp.note) begin bad++; $display("FAIL single_note got=%0d want=%0d", note, exp.note); end
        total++; if (busy !== 1'b1)     begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        while (busy === 1'b1 && len < 100) begin
            if (note !== exp.note) held_bad = 1;
            if (gate === 1'b1) begin
                if (lo != 0) order_bad = 1;
                hi++;
            end else begin
                lo++;
            end
            len++;
            tick();
        end
        total++; if (len != exp.len)       begin bad++; $display("FAIL single_len got=%0d want=%0d", len, exp.len); end
        total++; if (hi != exp.len - int'(GAP)) begin bad++; $display("FAIL single_gate_hi got=%0d want=%0d", hi, exp.len - int'(GAP)); end
        total++; if (lo != int'(GAP))      begin bad++; $display("FAIL single_gate_lo got=%0d want=%0d", lo, GAP); end
        total++; if (order_bad || held_bad) begin bad++; $display("FAIL single_shape order=%0d held=%0d want=0/0", order_bad, held_bad); end
        total++; if (note !== 8'd0)        begin bad++; $display("FAIL single_end_note got=%0d want=0", note); end
    endtask

    task automatic test_back_to_back();
        sb_item_t exp;
        int len, lo;
        write_entry(16'h0119, 1'b1);
        write_entry(16'h011B, 1'b1);
        for (int n = 0; n < 2; n++) begin
            exp = sb_q.pop_front();
            total++; if (note !== exp.note || busy !== 1'b1) begin bad++; $display("FAIL b2b_note%0d got=%0d busy=%b want=%0d busy=1", n, note, busy, exp.note); end
            len = 0; lo = 0;
            while (note === exp.note && busy === 1'b1 && len < 100) begin
                if (gate !== 1'b1) lo++;
                len++;
                tick();
            end
            total++; if (len != exp.len)  begin bad++; $display("FAIL b2b_len%0d got=%0d want=%0d", n, len, exp.len); end
            total++; if (lo != int'(GAP)) begin bad++; $display("FAIL b2b_gap%0d got=%0d want=%0d", n, lo, GAP); end
        end
        total++; if (note !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got note=%0d busy=%b want=0/0", note, busy); end
    endtask

    task automatic test_zero_dur();
        sb_item_t exp;
        int len;
        write_entry(16'h0019, 1'b0);
        write_entry(16'h0116, 1'b1);
        total++; if (note !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL zd_skip got note=%0d busy=%b want=0/0", note, busy); end
        tick();
        exp = sb_q.pop_front();
        total++; if (note !== exp.note) begin bad++; $display("FAIL zd_note got=%0d want=%0d", note, exp.note); end
        len = 0;
        while (busy === 1'b1 && len < 100) begin len++; tick(); end
        total++; if (len != exp.len) begin bad++; $display("FAIL zd_len got=%0d want=%0d", len, exp.len); end
        // zero-duration entry reached at the end of a playing note
        pause = 1'b1;
        write_entry(16'h0121, 1'b1);
        write_entry(16'h0023, 1'b0);
        write_entry(16'h0124, 1'b1);
        pause = 1'b0;
        tick();
        for (int n = 0; n < 2; n++) begin
            exp = sb_q.pop_front();
            total++; if (note !== exp.note) begin bad++; $display("FAIL zd_end_note%0d got=%0d want=%0d", n, note, exp.note); end
            len = 0;
            while (busy === 1'b1 && len < 100) begin len++; tick(); end
            total++; if (len != exp.len) begin bad++; $display("FAIL zd_end_len%0d got=%0d want=%0d", n, len, exp.len); end
            total++; if (note !== 8'd0) begin bad++; $display("FAIL zd_end_idle%0d got=%0d want=0", n, note); end
            if (n == 0) tick();
        end
    endtask

    task automatic test_pause();
        sb_item_t exp;
        int len = 0, paused = 0, paused_bad = 0;
        logic gate_resume = 1'b0;
        write_entry(16'h021D, 1'b1);
        tick();
        exp = sb_q.pop_front();
        total++; if (note !== exp.note) begin bad++; $display("FAIL pause_note got=%0d want=%0d", note, exp.note); end
        while (busy === 1'b1 && len < 200) begin
            if (len == 5) pause = 1'b1;
            if (len == 8) pause = 1'b0;
            tick();
            len++;
            if (pause === 1'b1) begin
                paused++;
                if (gate !== 1'b0 || note !== exp.note) paused_bad++;
            end
            if (len == 9) gate_resume = gate;
        end
        total++; if (paused != 3 || paused_bad != 0) begin bad++; $display("FAIL pause_hold got=%0d/%0d want=3/0", paused, paused_bad); end
        total++; if (gate_resume !== 1'b1) begin bad++; $display("FAIL pause_resume got=%b want=1", gate_resume); end
        total++; if (len != exp.len + 3) begin bad++; $display("FAIL pause_len got=%0d want=%0d", len, exp.len + 3); end
    endtask

    task automatic test_overflow();
        sb_item_t exp;
        int len;
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            write_entry(16'h0131 + 16'(i), (i < int'(DEPTH)));
        end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d want=4", count); end
        total++; if (full !== 1'b1 || overflow !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ovf_flags got full=%b ovf=%b busy=%b want=1/1/0", full, overflow, busy); end
        pause = 1'b0;
        tick();
        for (int n = 0; n < int'(DEPTH); n++) begin
            exp = sb_q.pop_front();
            total++; if (note !== exp.note) begin bad++; $display("FAIL ovf_note%0d got=%0d want=%0d", n, note, exp.note); end
            len = 0;
            while (note === exp.note && busy === 1'b1 && len < 100) begin len++; tick(); end
            total++; if (len != exp.len) begin bad++; $display("FAIL ovf_len%0d got=%0d want=%0d", n, len, exp.len); end
        end
        tick();
        tick();
        total++; if (note !== 8'd0 || busy !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL ovf_fifth got note=%0d busy=%b count=%0d want=0/0/0", note, busy, count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    endtask

    task automatic test_reset_mid_play();
        pause = 1'b1;
        write_entry(16'h0241, 1'b0);
        write_entry(16'h0142, 1'b0);
        write_entry(16'h0143, 1'b0);
        pause = 1'b0;
        tick();
        tick();
        total++; if (busy !== 1'b1 || count !== 3'd2) begin bad++; $display("FAIL rmp_pre got busy=%b count=%0d want=1/2", busy, count); end
        reset = 1'b1;
        write_entry(16'h0144, 1'b0);
        reset = 1'b0;
        total++; if (note !== 8'd0 || gate !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmp_out got note=%0d gate=%b busy=%b want=0/0/0", note, gate, busy); end
        total++; if (count !== 3'd0 || overflow !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL rmp_fifo got count=%0d ovf=%b full=%b want=0/0/0", count, overflow, full); end
        tick();
        tick();
        total++; if (busy !== 1'b0 || note !== 8'd0) begin bad++; $display("FAIL rmp_after got busy=%b note=%0d want=0/0", busy, note); end
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        pause   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_dur();
        test_pause();
        test_overflow();
        test_reset_mid_play();
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter DEPTH, default 16: note FIFO entries; power of two.
REQ-002 Parameter BEAT_CYCLES, default 4194304: clk cycles per beat.
REQ-003 Parameter GAP_CYCLES, default 262144: silent articulation cycles at the end of each note; must be less than BEAT_CYCLES.
REQ-004 One clock; reset is synchronous and active-high: clk  input  1  system clock, 25 MHz.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 wr_en  input  1  CPU write strobe, one entry per cycle high.
REQ-007 wr_data  input  16  [7:0] note code (octave*12+semitone; 0 = rest); [15:8] duration in beats.
REQ-008 pause  input  1  freeze playback while high.
REQ-009 note  output  8  note code driven to the tone generator; 0 = silent.
REQ-010 gate  output  1  high while the note must sound.
REQ-011 busy  output  1  high in PLAY state.
REQ-012 full  output  1  FIFO holds DEPTH entries.
REQ-013 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 overflow  output  1  sticky; set when a write is dropped.

Function
REQ-015 Write accepted iff wr_en=1 and full=0 at the sampling edge; a write while full is dropped regardless of a same-cycle pop, and overflow sets.
REQ-016 Simultaneous accepted write and pop leave count unchanged; pointers wrap modulo DEPTH.
REQ-017 FSM states: IDLE, PLAY.
REQ-018 IDLE: note=0, gate=0, busy=0; on an edge with count>0 and pause=0, pop the head entry.
REQ-019 Popped entry with duration 0 is discarded; the FSM remains in or returns to IDLE.
REQ-020 Popped entry with duration D>0: latch note, beats_left=D, cycle_cnt=0; go to PLAY.
REQ-021 Latency: a write into an empty FIFO in IDLE at edge t makes note valid after edge t+1.
REQ-022 PLAY: cycle_cnt increments each unpaused cycle; on reaching BEAT_CYCLES-1 it wraps to 0 and beats_left decrements.
REQ-023 A note plays for exactly D*BEAT_CYCLES unpaused cycles.
REQ-024 gate=1 in PLAY when note!=0, except gate=0 when beats_left=1 and cycle_cnt>=BEAT_CYCLES-GAP_CYCLES.
REQ-025 Rest entries (note=0) keep gate=0 for their whole duration.
REQ-026 On the last cycle of a note: if count>0, pop and load the next entry on the same edge (no idle cycle); otherwise go to IDLE with note=0.
REQ-027 A zero-duration entry popped at note end is discarded, and the next entry is considered on the following edge.
REQ-028 pause=1: counters and FIFO pops hold, gate=0, note holds its value; resume continues from the held count.
REQ-029 Counter widths cover BEAT_CYCLES-1 and 255 beats without overflow.

Reset
REQ-030 When reset is sampled high: state=IDLE, FIFO empty (count=0, pointers 0), note=0, gate=0, busy=0, full=0, overflow=0, counters 0.
REQ-031 Reset takes priority over every input, including during PLAY and on the same edge as wr_en.

Structure
REQ-032 Shared package audio_pkg shall hold NOTE_REST=0, default BEAT_CYCLES/GAP_CYCLES/DEPTH, the wr_data field positions, and the FSM state encoding.
REQ-033 One sub-module, note_fifo: synchronous FIFO (16-bit wide, DEPTH deep, push/pop/full/count/overflow); FSM and timing counters live in note_sequencer.

Verification (BEAT_CYCLES=8, GAP_CYCLES=2, DEPTH=4)
REQ-034 Write 0x0219 at edge 0 -> note=25 after edge 1; gate high 14 cycles, low 2; note=0 and busy=0 after 16 cycles.
REQ-035 Write 0x0119, 0x011B back-to-back -> note goes 25 then 27 on consecutive edges with no IDLE cycle; gate low exactly 2 cycles at the end of each note.
REQ-036 Write 5 entries while idle-blocked by pause -> count=4, full=1, overflow=1; the 5th entry is never played.
REQ-037 Write 0x0019 then 0x0116 -> 0x0019 is discarded; note=22 plays for 8 cycles.
REQ-038 Assert pause 3 cycles mid-note -> gate=0 and note held during the pause; total note length extends by exactly 3 cycles.
REQ-039 Assert reset mid-PLAY with 2 entries queued -> next cycle note=0, gate=0, count=0, overflow=0, state IDLE.
